register_file_agu: RTL and testbench



---
 rtl/v30mz_pkg.sv | 21 ++
 rtl/register_file_agu_if.sv | 36 +++
 rtl/register_file_agu_pa_adder.sv | 23 ++
 rtl/register_file_agu.sv | 42 ++++
 tb/tb_register_file_agu.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/v30mz_pkg.sv
// Shared V30MZ definitions: register indices and effective-address factor bit positions.
package v30mz_pkg;

  typedef enum logic [2:0] {
    REG_AW = 3'd0,
    REG_CW = 3'd1,
    REG_DW = 3'd2,
    REG_BW = 3'd3,
    REG_SP = 3'd4,
    REG_BP = 3'd5,
    REG_IX = 3'd6,
    REG_IY = 3'd7
  } reg_id_e;

  localparam int unsigned FACTOR_NO_BASE  = 2;
  localparam int unsigned FACTOR_NO_INDEX = 1;
  localparam int unsigned FACTOR_NO_DISP  = 0;

  localparam int unsigned NUM_REGS = 8;

endpackage

// File: rtl/register_file_agu_if.sv
// Register-file write port and address-generation bus between microsequencer, AGU and BCU.
// REGFILE_BYTE_WRITE_EN adds the write_byte / write_hi lane-select signals.
interface register_file_agu_if;
  logic             we;
  logic [2:0]       write_id;
  logic [15:0]      write_data;
`ifdef REGFILE_BYTE_WRITE_EN
  logic             write_byte;
  logic             write_hi;
`endif
  logic [7:0][15:0] registers;
  logic [2:0]       factors;
  logic [15:0]      segment;
  logic [2:0]       base_id;
  logic [2:0]       index_id;
  logic [15:0]      displacement;
  logic [19:0]      physical_address;

  modport master (
    output we, write_id, write_data,
`ifdef REGFILE_BYTE_WRITE_EN
    output write_byte, write_hi,
`endif
    output factors, segment, base_id, index_id, displacement,
    input  registers, physical_address
  );

  modport slave (
    input  we, write_id, write_data,
`ifdef REGFILE_BYTE_WRITE_EN
    input  write_byte, write_hi,
`endif
    input  factors, segment, base_id, index_id, displacement,
    output registers, physical_address
  );
endinterface

// File: rtl/register_file_agu_pa_adder.sv
// Combinational effective-address and 20-bit physical-address adder.
module pa_adder
  import v30mz_pkg::*;
(
  input  logic [2:0]  factors,
  input  logic [15:0] segment,
  input  logic [15:0] base,
  input  logic [15:0] index,
  input  logic [15:0] displacement,
  output logic [19:0] physical_address
);

  logic [15:0] ea;

  // Both sums truncate to their result width, giving the 16-bit EA wrap and the 20-bit PA wrap.
  always_comb begin
    ea = (factors[FACTOR_NO_BASE]  ? 16'h0000 : base)
       + (factors[FACTOR_NO_INDEX] ? 16'h0000 : index)
       + (factors[FACTOR_NO_DISP]  ? 16'h0000 : displacement);
    physical_address = {segment, 4'h0} + {4'h0, ea};
  end

endmodule

// File: rtl/register_file_agu.sv
// V30MZ register file (8x16, one synchronous write port) plus memory-operand address generation.
// REGFILE_BYTE_WRITE_EN enables byte-lane writes via write_byte / write_hi.
module register_file_agu
  import v30mz_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  register_file_agu_if.slave  bus
);

  logic [7:0][15:0] regs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else if (bus.we) begin
`ifdef REGFILE_BYTE_WRITE_EN
      if (!bus.write_byte) begin
        regs[bus.write_id] <= bus.write_data;
      end else if (bus.write_hi) begin
        regs[bus.write_id][15:8] <= bus.write_data[7:0];
      end else begin
        regs[bus.write_id][7:0] <= bus.write_data[7:0];
      end
`else
      regs[bus.write_id] <= bus.write_data;
`endif
    end
  end

  assign bus.registers = regs;

  pa_adder u_pa_adder (
    .factors          (bus.factors),
    .segment          (bus.segment),
    .base             (regs[bus.base_id]),
    .index            (regs[bus.index_id]),
    .displacement     (bus.displacement),
    .physical_address (bus.physical_address)
  );

endmodule

// File: tb/tb_register_file_agu.sv
// Self-checking bench for register_file_agu: directed cases plus randomized traffic vs. an array model.
module tb_register_file_agu;
  import v30mz_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned model [8];

  register_file_agu_if bus();

  register_file_agu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] exp_pa();
    int unsigned ea;
    int unsigned seg;
    ea = 0;
    if (!bus.factors[2]) ea += model[bus.base_id];
    if (!bus.factors[1]) ea += model[bus.index_id];
    if (!bus.factors[0]) ea += bus.displacement;
    ea  = ea % 65536;
    seg = bus.segment;
    return 20'((seg * 16 + ea) % 1048576);
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_reg%0d", tag, i), {16'h0, bus.registers[i]}, model[i]);
    check({tag, "_pa"}, {12'h0, bus.physical_address}, {12'h0, exp_pa()});
  endtask

  task automatic idle_inputs();
    bus.we = 1'b0;
    bus.write_id = '0;
    bus.write_data = '0;
`ifdef REGFILE_BYTE_WRITE_EN
    bus.write_byte = 1'b0;
    bus.write_hi = 1'b0;
`endif
  endtask

  task automatic wr(input logic [2:0] id, input logic [15:0] d);
    @(negedge clk);
    bus.we = 1'b1;
    bus.write_id = id;
    bus.write_data = d;
`ifdef REGFILE_BYTE_WRITE_EN
    bus.write_byte = 1'b0;
`endif
    @(posedge clk);
    model[id] = d;
    #1;
    bus.we = 1'b0;
  endtask

`ifdef REGFILE_BYTE_WRITE_EN
  task automatic wr_byte(input logic [2:0] id, input logic [7:0] d, input logic hi);
    @(negedge clk);
    bus.we = 1'b1;
    bus.write_id = id;
    bus.write_data = {8'hEE, d};
    bus.write_byte = 1'b1;
    bus.write_hi = hi;
    @(posedge clk);
    if (hi) model[id] = (model[id] & 32'h00FF) | (32'(d) << 8);
    else    model[id] = (model[id] & 32'hFF00) | 32'(d);
    #1;
    bus.we = 1'b0;
    bus.write_byte = 1'b0;
  endtask
`endif

  initial begin
    logic [15:0] v;
    idle_inputs();
    bus.factors = 3'b111;
    bus.segment = '0;
    bus.base_id = '0;
    bus.index_id = '0;
    bus.displacement = '0;
    for (int i = 0; i < 8; i++) model[i] = 0;

    #2;
    check_all("por");
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset between edges
    wr(REG_BW, 16'h1234);
    check("bw_1234", {16'h0, bus.registers[REG_BW]}, 32'h1234);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) model[i] = 0;
    check_all("async_rst");
    check("async_rst_pa0", {12'h0, bus.physical_address}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Write/readback, no bypass during the write cycle
    for (int k = 0; k < 8; k++) begin
      v = 16'(16'h1111 * k);
      @(negedge clk);
      bus.we = 1'b1;
      bus.write_id = 3'(k);
      bus.write_data = v;
      #1;
      check($sformatf("nobypass_%0d", k), {16'h0, bus.registers[k]}, model[k]);
      @(posedge clk);
      model[k] = v;
      #1;
      check($sformatf("wr_%0d", k), {16'h0, bus.registers[k]}, {16'h0, v});
    end
    @(negedge clk);
    bus.we = 1'b0;
    bus.write_data = 16'hFFFF;
    @(posedge clk);
    #1;
    check_all("we0_hold");

    // Full EA form with negative displacement
    wr(REG_BW, 16'h0100);
    wr(REG_IX, 16'h0020);
    bus.base_id = REG_BW;
    bus.index_id = REG_IX;
    bus.displacement = 16'hFFFE;
    bus.segment = 16'h1000;
    bus.factors = 3'b000;
    #1;
    check("ea_full", {12'h0, bus.physical_address}, 32'h1011E);

    // EA wraps at 16 bits
    wr(REG_BP, 16'hFFF0);
    bus.base_id = REG_BP;
    bus.displacement = 16'h0020;
    bus.factors = 3'b010;
    bus.segment = 16'hF000;
    #1;
    check("ea_wrap", {12'h0, bus.physical_address}, 32'hF0010);

    bus.segment = 16'hFFFF;
    bus.factors = 3'b111;
    bus.displacement = 16'hFFFF;
    #1;
    check("seg_only", {12'h0, bus.physical_address}, 32'hFFFF0);

    bus.factors = 3'b110;
    bus.displacement = 16'h0020;
    #1;
    check("pa_wrap", {12'h0, bus.physical_address}, 32'h00010);

    // base == index adds the register twice
    bus.base_id = REG_BW;
    bus.index_id = REG_BW;
    bus.segment = 16'h0000;
    bus.factors = 3'b001;
    #1;
    check("base_eq_index", {12'h0, bus.physical_address}, 32'h00200);

    // Write-to-address dependency
    bus.factors = 3'b011;
    bus.segment = 16'h0000;
    wr(REG_BW, 16'h0000);
    @(negedge clk);
    bus.we = 1'b1;
    bus.write_id = REG_BW;
    bus.write_data = 16'hABCD;
    #1;
    check("dep_before", {12'h0, bus.physical_address}, 32'h00000);
    @(posedge clk);
    model[REG_BW] = 16'hABCD;
    #1;
    bus.we = 1'b0;
    check("dep_after", {12'h0, bus.physical_address}, 32'h0ABCD);

`ifdef REGFILE_BYTE_WRITE_EN
    wr(REG_AW, 16'h1234);
    wr_byte(REG_AW, 8'h56, 1'b1);
    check("byte_hi", {16'h0, bus.registers[REG_AW]}, 32'h5634);
    wr_byte(REG_AW, 8'h78, 1'b0);
    check("byte_lo", {16'h0, bus.registers[REG_AW]}, 32'h5678);
`endif

    // Randomized traffic against the array model
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      bus.we = 1'($urandom_range(0, 1));
      bus.write_id = 3'($urandom_range(0, 7));
      bus.write_data = 16'($urandom);
`ifdef REGFILE_BYTE_WRITE_EN
      bus.write_byte = 1'($urandom_range(0, 1));
      bus.write_hi = 1'($urandom_range(0, 1));
`endif
      bus.factors = 3'($urandom_range(0, 7));
      bus.segment = 16'($urandom);
      bus.base_id = 3'($urandom_range(0, 7));
      bus.index_id = 3'($urandom_range(0, 7));
      bus.displacement = 16'($urandom);
      #1;
      check_all($sformatf("rnd%0d", n));
      @(posedge clk);
      if (bus.we) begin
`ifdef REGFILE_BYTE_WRITE_EN
        if (!bus.write_byte)
          model[bus.write_id] = bus.write_data;
        else if (bus.write_hi)
          model[bus.write_id] = (model[bus.write_id] & 32'h00FF) | (32'(bus.write_data[7:0]) << 8);
        else
          model[bus.write_id] = (model[bus.write_id] & 32'hFF00) | 32'(bus.write_data[7:0]);
`else
        model[bus.write_id] = bus.write_data;
`endif
      end
    end
    #1;
    check_all("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
